// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler: serial-in/parallel-out front end for a negative-edge,
// active-low-enable register. Collects WIDTH serial bits into a word and pulses
// Enbar low for one Clk cycle when the word is presented on out.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit,
// a PAR state and the ParityErr output).
module serial_byte_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Sin,
    input  logic             SinValid,
    input  logic             Clear,
    output logic [WIDTH-1:0] out,
    output logic             Enbar,
    output logic             Busy,
`ifdef PARITY_CHECK_EN
    output logic             ParityErr,
`endif
    output logic [3:0]       BitCount
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, STROBE = 2'd2, PAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, STROBE = 2'd2} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] out_n;
    logic [3:0]       count, count_n;
`ifdef PARITY_CHECK_EN
    logic             perr, perr_n;
`endif

    // Shift register with the current serial bit merged in, in the configured order
    always_comb begin
        if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], Sin};
        else           shifted = {Sin, sreg[WIDTH-1:1]};
    end

    // Next-state, datapath and output-load decisions
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        count_n = count;
        out_n   = out;
`ifdef PARITY_CHECK_EN
        perr_n  = 1'b0;
`endif
        unique case (state)
            IDLE, STROBE: begin
                // STROBE lasts one cycle regardless of Clear; a valid bit here starts the next word
                if (Clear) begin
                    state_n = IDLE;
                    count_n = '0;
                    sreg_n  = '0;
                end else if (SinValid) begin
                    state_n = SHIFT;
                    count_n = 4'd1;
                    sreg_n  = shifted;
                end else begin
                    state_n = IDLE;
                    count_n = '0;
                end
            end
            SHIFT: begin
                if (Clear) begin
                    state_n = IDLE;
                    count_n = '0;
                    sreg_n  = '0;
                end else if (SinValid) begin
                    sreg_n  = shifted;
                    count_n = count + 4'd1;
                    if (count == 4'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_n = PAR;
`else
                        state_n = STROBE;
                        out_n   = shifted;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PAR: begin
                if (Clear) begin
                    state_n = IDLE;
                    count_n = '0;
                    sreg_n  = '0;
                end else if (SinValid) begin
                    if (Sin == ^sreg) begin
                        state_n = STROBE;
                        out_n   = sreg;
                    end else begin
                        state_n = IDLE;
                        count_n = '0;
                        perr_n  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
            out   <= '0;
`ifdef PARITY_CHECK_EN
            perr  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            count <= count_n;
            out   <= out_n;
`ifdef PARITY_CHECK_EN
            perr  <= perr_n;
`endif
        end
    end

    // Outputs decoded from registered state, stable across the falling edge
    always_comb begin
        Enbar    = (state != STROBE);
`ifdef PARITY_CHECK_EN
        Busy      = (state == SHIFT) || (state == PAR);
        ParityErr = perr;
`else
        Busy     = (state == SHIFT);
`endif
        BitCount = count;
    end

endmodule
